// File: rtl/oneton_demux_pkg.sv
// Shared types and helpers for the 1-to-N M-bit stream demultiplexer.
// Holds the packet-lock state encoding and the select/counter width helpers.
package oneton_demux_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Wide enough for any practical drop counter saturation value.
   typedef logic [31:0] cnt_max_t;

   function automatic int sel_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic cnt_max_t cnt_max(input int w);
      return cnt_max_t'((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/oneton_mbit_demux_skid_buf.sv
// Two-entry skid buffer: in_ready is a registered not-full flag, so the
// downstream ready never reaches the upstream ready combinationally.
module mbit_skid_buf #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [W-1:0] r_head;
   logic [W-1:0] r_tail;
   logic [1:0]   r_count;
   logic         r_not_full;
   logic         r_valid;

   logic         w_push;
   logic         w_pop;
   logic [1:0]   w_count_next;

   assign w_push       = in_valid && r_not_full;
   assign w_pop        = r_valid && out_ready;
   assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

   assign in_ready  = r_not_full;
   assign out_valid = r_valid;
   assign out_data  = r_head;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= 2'd0;
         r_not_full <= 1'b1;
         r_valid    <= 1'b0;
      end else begin
         r_count    <= w_count_next;
         r_not_full <= (w_count_next != 2'd2);
         r_valid    <= (w_count_next != 2'd0);
         // The head register always presents the oldest beat.
         case (r_count)
            2'd0: begin
               if (w_push) r_head <= in_data;
            end
            2'd1: begin
               if (w_push && w_pop) r_head <= in_data;
               else if (w_push)     r_tail <= in_data;
            end
            default: begin
               if (w_pop) r_head <= r_tail;
            end
         endcase
      end
   end

endmodule

// File: rtl/oneton_mbit_demux.sv
// 1-to-N M-bit stream demultiplexer with a packet lock on the destination
// and a two-entry skid buffer per output; out-of-range beats are counted and dropped.
module oneton_mbit_demux
   import oneton_demux_pkg::*;
#(
   parameter  int N     = 16,
   parameter  int M     = 32,
   parameter  int CNT_W = 16,
   localparam int SEL_W = sel_width(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [M-1:0]     s_data,
   input  logic             s_last,
   input  logic [SEL_W-1:0] s_sel,
   output logic [N-1:0]     m_valid,
   input  logic [N-1:0]     m_ready,
   output logic [N*M-1:0]   m_data,
   output logic [N-1:0]     m_last,
   output logic             drop_pulse,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam cnt_max_t DROP_MAX = cnt_max(CNT_W);

   state_t             r_state;
   logic [SEL_W-1:0]   r_lock_sel;
   logic               r_drop_pulse;
   logic [CNT_W-1:0]   r_drop_cnt;

   logic [SEL_W-1:0]   w_route;
   logic               w_route_ok;
   logic               w_accept;
   logic               w_drop;
   logic [N-1:0]       w_hit;
   logic [N-1:0]       w_in_ready;
   logic [M:0]         w_out_data [N];

   assign w_route = (r_state == ST_IDLE) ? s_sel : r_lock_sel;
   // Extra bit keeps the range test meaningful when N is a power of two.
   assign w_route_ok = ({1'b0, w_route} < (SEL_W + 1)'(N));

   assign s_ready  = !rst && (w_route_ok ? |(w_in_ready & w_hit) : 1'b1);
   assign w_accept = s_valid && s_ready;
   assign w_drop   = w_accept && !w_route_ok;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_out
         assign w_hit[gi] = (w_route == SEL_W'(gi));

         mbit_skid_buf #(
            .W (M + 1)
         ) u_skid (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (s_valid && w_route_ok && w_hit[gi]),
            .in_ready  (w_in_ready[gi]),
            .in_data   ({s_last, s_data}),
            .out_valid (m_valid[gi]),
            .out_ready (m_ready[gi]),
            .out_data  (w_out_data[gi])
         );

         assign m_data[gi*M +: M] = w_out_data[gi][M-1:0];
         assign m_last[gi]        = w_out_data[gi][M];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_lock_sel   <= '0;
         r_drop_pulse <= 1'b0;
         r_drop_cnt   <= '0;
      end else begin
         r_drop_pulse <= w_drop;
         if (w_drop && (r_drop_cnt != DROP_MAX[CNT_W-1:0]))
            r_drop_cnt <= r_drop_cnt + 1'b1;
         if (w_accept) begin
            case (r_state)
               ST_IDLE: begin
                  if (!s_last) begin
                     r_state    <= ST_BUSY;
                     r_lock_sel <= s_sel;
                  end
               end
               default: begin
                  if (s_last) r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign drop_pulse = r_drop_pulse;
   assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_oneton_mbit_demux.sv
// Directed bench for oneton_mbit_demux with N=5, M=8, CNT_W=2; expected
// values are hand-derived cycle by cycle from the intended behaviour.
module tb_oneton_mbit_demux;

   localparam int N     = 5;
   localparam int M     = 8;
   localparam int CNT_W = 2;
   localparam int SEL_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             s_valid;
   logic             s_ready;
   logic [M-1:0]     s_data;
   logic             s_last;
   logic [SEL_W-1:0] s_sel;
   logic [N-1:0]     m_valid;
   logic [N-1:0]     m_ready;
   logic [N*M-1:0]   m_data;
   logic [N-1:0]     m_last;
   logic             drop_pulse;
   logic [CNT_W-1:0] drop_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   oneton_mbit_demux #(
      .N     (N),
      .M     (M),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .s_sel      (s_sel),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .drop_pulse (drop_pulse),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      else begin
         n_pass++;
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [SEL_W-1:0] sel,
                        input logic [M-1:0] d, input logic last);
      s_valid = v;
      s_sel   = sel;
      s_data  = d;
      s_last  = last;
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      m_ready = 5'b11111;
      drive(1'b0, 3'd0, 8'h00, 1'b0);
      cyc();
      cyc();
      chk("rst_m_valid", 64'(m_valid), 64'h0);
      chk("rst_m_data", 64'(m_data), 64'h0);
      chk("rst_s_ready", 64'(s_ready), 64'h0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
      rst = 1'b0;

      // Single-beat packet to output 2.
      drive(1'b1, 3'd2, 8'hA5, 1'b1);
      chk("t1_s_ready", 64'(s_ready), 64'h1);
      cyc();
      drive(1'b0, 3'd0, 8'h00, 1'b0);
      chk("t1_m_valid", 64'(m_valid), 64'h04);
      chk("t1_data", 64'(m_data[23:16]), 64'hA5);
      chk("t1_last", 64'(m_last[2]), 64'h1);
      cyc();
      chk("t1_drained", 64'(m_valid), 64'h0);

      // Three-beat packet locked to output 1 while s_sel wanders to 3.
      drive(1'b1, 3'd1, 8'h11, 1'b0);
      cyc();
      drive(1'b1, 3'd3, 8'h22, 1'b0);
      chk("t2_b1_valid", 64'(m_valid), 64'h02);
      chk("t2_b1_data", 64'(m_data[15:8]), 64'h11);
      chk("t2_b1_last", 64'(m_last[1]), 64'h0);
      cyc();
      drive(1'b1, 3'd3, 8'h33, 1'b1);
      chk("t2_b2_valid", 64'(m_valid), 64'h02);
      chk("t2_b2_data", 64'(m_data[15:8]), 64'h22);
      chk("t2_b2_last", 64'(m_last[1]), 64'h0);
      cyc();
      drive(1'b0, 3'd0, 8'h00, 1'b0);
      chk("t2_b3_valid", 64'(m_valid), 64'h02);
      chk("t2_b3_data", 64'(m_data[15:8]), 64'h33);
      chk("t2_b3_last", 64'(m_last[1]), 64'h1);
      cyc();
      chk("t2_drained", 64'(m_valid), 64'h0);

      // Output 0 stalled: two beats fill its skid, output 3 still flows.
      m_ready = 5'b11110;
      drive(1'b1, 3'd0, 8'h40, 1'b1);
      cyc();
      drive(1'b1, 3'd0, 8'h41, 1'b1);
      chk("t3_ready_1full", 64'(s_ready), 64'h1);
      cyc();
      drive(1'b1, 3'd0, 8'h42, 1'b1);
      chk("t3_ready_full", 64'(s_ready), 64'h0);
      chk("t3_head_a", 64'(m_data[7:0]), 64'h40);
      cyc();
      chk("t3_head_hold", 64'(m_data[7:0]), 64'h40);
      chk("t3_ready_hold", 64'(s_ready), 64'h0);
      drive(1'b1, 3'd3, 8'h77, 1'b1);
      chk("t3_ready_sel3", 64'(s_ready), 64'h1);
      cyc();
      chk("t3_valid_0_3", 64'(m_valid), 64'h09);
      chk("t3_data3", 64'(m_data[31:24]), 64'h77);
      m_ready = 5'b11111;
      drive(1'b1, 3'd0, 8'h42, 1'b1);
      chk("t3_ready_nocomb", 64'(s_ready), 64'h0);
      cyc();
      chk("t3_drain_41", 64'(m_data[7:0]), 64'h41);
      chk("t3_ready_back", 64'(s_ready), 64'h1);
      cyc();
      chk("t3_drain_42", 64'(m_data[7:0]), 64'h42);
      chk("t3_valid_only0", 64'(m_valid), 64'h01);
      drive(1'b1, 3'd0, 8'h43, 1'b1);
      cyc();
      drive(1'b0, 3'd0, 8'h00, 1'b0);
      chk("t3_drain_43", 64'(m_data[7:0]), 64'h43);
      cyc();
      chk("t3_empty", 64'(m_valid), 64'h0);

      // Out-of-range packet (sel=6) is dropped whole, then saturation.
      drive(1'b1, 3'd6, 8'h01, 1'b0);
      chk("t4_ready_b1", 64'(s_ready), 64'h1);
      cyc();
      chk("t4_pulse_b1", 64'(drop_pulse), 64'h1);
      chk("t4_cnt_b1", 64'(drop_cnt), 64'h1);
      drive(1'b1, 3'd2, 8'h02, 1'b0);
      chk("t4_ready_b2", 64'(s_ready), 64'h1);
      cyc();
      chk("t4_cnt_b2", 64'(drop_cnt), 64'h2);
      chk("t4_no_valid_b2", 64'(m_valid), 64'h0);
      drive(1'b1, 3'd2, 8'h03, 1'b1);
      cyc();
      drive(1'b0, 3'd0, 8'h00, 1'b0);
      chk("t4_cnt_b3", 64'(drop_cnt), 64'h3);
      chk("t4_pulse_b3", 64'(drop_pulse), 64'h1);
      chk("t4_no_valid_b3", 64'(m_valid), 64'h0);
      cyc();
      chk("t4_pulse_off", 64'(drop_pulse), 64'h0);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 3'd7, 8'(i), 1'b1);
         cyc();
      end
      drive(1'b0, 3'd0, 8'h00, 1'b0);
      chk("t5_sat_pulse", 64'(drop_pulse), 64'h1);
      chk("t5_sat_cnt", 64'(drop_cnt), 64'h3);

      // Reset while locked to output 1 with two beats buffered.
      m_ready = 5'b11101;
      drive(1'b1, 3'd1, 8'h50, 1'b0);
      cyc();
      drive(1'b1, 3'd1, 8'h51, 1'b0);
      cyc();
      rst = 1'b1;
      drive(1'b0, 3'd0, 8'h00, 1'b0);
      chk("t6_buffered", 64'(m_valid), 64'h02);
      chk("t6_ready_in_rst", 64'(s_ready), 64'h0);
      cyc();
      chk("t6_valid_cleared", 64'(m_valid), 64'h0);
      chk("t6_cnt_cleared", 64'(drop_cnt), 64'h0);
      rst     = 1'b0;
      m_ready = 5'b11111;
      drive(1'b1, 3'd0, 8'h60, 1'b1);
      chk("t6_ready_after", 64'(s_ready), 64'h1);
      cyc();
      drive(1'b0, 3'd0, 8'h00, 1'b0);
      chk("t6_route0", 64'(m_valid), 64'h01);
      chk("t6_data0", 64'(m_data[7:0]), 64'h60);
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/oneton_mbit_demux.md
Name: oneton_mbit_demux

Overview:
- 1-to-N, M-bit stream demultiplexer. It is the distribution-side counterpart of the N-to-1 M-bit mux.
- Routes valid/ready beats from one source port to one of N destination ports, using a flat packed output bus.
- Packet-locked: the destination is sampled on the first beat of a packet and held until the last beat.
- Each output has a 2-entry skid buffer, so no destination ready signal feeds s_ready combinationally.

Parameters:
- N, 16, number of destination ports (need not be a power of 2).
- M, 32, data width per beat.
- CNT_W, 16, width of the drop counter.
- SEL_W, $clog2(N) (N=1 gives 1), select width; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  source beat valid.
- s_ready  out  1  source beat accepted when s_valid&&s_ready.
- s_data  in  M  source beat data.
- s_last  in  1  last beat of packet.
- s_sel  in  SEL_W  destination index; sampled on first beat only.
- m_valid  out  N  per-destination valid.
- m_ready  in  N  per-destination ready.
- m_data  out  N*M  destination i data at [(i+1)*M-1 : i*M].
- m_last  out  N  per-destination last.
- drop_pulse  out  1  one-cycle pulse per dropped beat.
- drop_cnt  out  CNT_W  saturating count of dropped beats.

Behaviour:
- Reset (rst=1 at posedge):
  - m_valid=0, m_last=0, m_data=0.
  - s_ready=0 (forced low while rst high).
  - drop_pulse=0, drop_cnt=0, FSM=IDLE, all skid buffers empty.
- Reset mid-packet: in-flight beats are discarded, the lock is cleared, and there is no partial flush.
- Route selection:
  - route = (FSM==IDLE) ? s_sel : lock_sel.
  - route_ok = (route < N).
- s_ready:
  - route_ok=1: s_ready = in_ready of skid[route], which is a registered not-full flag.
  - route_ok=0: s_ready=1.
  - s_ready may depend on s_sel, but never on s_valid or m_ready in the same cycle.
- Accept: a beat is accepted when s_valid&&s_ready.
  - route_ok=1: the beat {data,last} is pushed into skid[route].
  - route_ok=0: the beat is dropped, drop_pulse=1 next cycle, and drop_cnt increments, saturating at 2^CNT_W-1.
- FSM (2 states):
  - IDLE → BUSY on an accepted beat with s_last=0; lock_sel <= s_sel.
  - BUSY → IDLE on an accepted beat with s_last=1.
  - A single-beat packet (s_last=1 in IDLE) stays in IDLE.
  - In BUSY, s_sel is ignored.
  - Out-of-range packets lock the same way, so the whole packet is dropped.
- Latency: a beat accepted at cycle t into an empty skid buffer gives m_valid[route]=1 at t+1.
- Throughput:
  - 1 beat/cycle sustained into one destination while its m_ready=1.
  - m_ready low for k cycles absorbs up to 2 beats, then s_ready drops for that route.
- Ordering is preserved per destination. Different destinations are independent; stalling destination j never blocks a packet routed to i≠j.
- m_data/m_last for output i hold stable while m_valid[i]=1 and m_ready[i]=0.
- m_valid never deasserts without a handshake.
- Skid buffer, same-cycle push and pop:
  - When full, in_ready=0, so no push can occur.
  - When holding 1 entry: occupancy stays 1, data order is preserved, in_ready stays 1.
- m_data of idle outputs holds its last value; it is not required to be zero.

Decomposition:
- Package oneton_demux_pkg: function sel_width(N), and typedef for the drop counter saturation max.
- Sub-module mbit_skid_buf (parameter W=M+1; ports clk, rst, in_valid, in_ready, in_data, out_valid, out_ready, out_data), instantiated N times in a generate loop.
- The top holds the FSM, route/lock logic and drop counter.

Test Plan:
- N=4, M=8, all m_ready=1. Single beats sel=2 data=0xA5 last=1 → m_valid[2]=1 at next cycle, m_data[23:16]=0xA5, other m_valid=0, FSM stays IDLE.
- 3-beat packet sel=1 (0x11,0x22,0x33 last on third); s_sel changed to 3 on beats 2–3 → all three beats appear on output 1 in order, and m_last[1]=1 only with 0x33.
- m_ready[0]=0, stream 4 beats to sel=0 → 2 beats accepted, then s_ready=0. Meanwhile a packet to sel=3 is accepted once the source presents it. Raise m_ready[0] → remaining beats drain in order with no loss or duplication.
- N=5, packet sel=6 of 3 beats → s_ready=1 on all beats, drop_pulse 3 times, drop_cnt=3, no m_valid.
- CNT_W=2, 5 dropped beats → drop_cnt saturates at 3.
- rst asserted in BUSY with 2 beats buffered on output 1 → next cycle m_valid=0, s_ready=0. After release, a new packet with sel=0 routes to output 0 with no stale lock.
